// File: rtl/pc_pkg.sv
// Shared front-end types: fetch address, front-end run state and redirect sources.
package pc_pkg;

   localparam int unsigned     PC_W      = 25;
   localparam logic [PC_W-1:0] BOOT_ADDR = 25'd16359;

   typedef logic [PC_W-1:0] pc_t;

   typedef enum logic {RUN, HALT} fe_state_e;

   typedef enum logic [1:0] {SRC_EX, SRC_DEC, SRC_PEND, SRC_RAS} redir_src_e;

endpackage

// File: rtl/pc_gen_if.sv
// Fetch-control bundle between the pipeline control (master) and pc_gen (slave).
interface pc_gen_if #(
   parameter int unsigned PC_W = 25
);
   logic            n_stall;
   logic            ex_redirect;
   logic [PC_W-1:0] ex_target;
   logic            dec_redirect;
   logic [PC_W-1:0] dec_target;
   logic            halt_req;
   logic            resume;
   logic            dec_call;
   logic            dec_ret;
   logic [PC_W-1:0] dec_link;
   logic [PC_W-1:0] pc;
   logic [PC_W-1:0] npc;
   logic            npc_enn;
   logic            flush;
   logic            fetch_valid;
   logic            halted;

   modport master (
      output n_stall, ex_redirect, ex_target, dec_redirect, dec_target,
             halt_req, resume, dec_call, dec_ret, dec_link,
      input  pc, npc, npc_enn, flush, fetch_valid, halted
   );

   modport slave (
      input  n_stall, ex_redirect, ex_target, dec_redirect, dec_target,
             halt_req, resume, dec_call, dec_ret, dec_link,
      output pc, npc, npc_enn, flush, fetch_valid, halted
   );
endinterface

// File: rtl/pc_gen_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module pc_gen_ras #(
   parameter int unsigned PC_W  = 25,
   parameter int unsigned DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            push_i,
   input  logic            pop_i,
   input  logic [PC_W-1:0] data_i,
   output logic [PC_W-1:0] top_o,
   output logic            empty_o
);
   localparam int unsigned PW   = $clog2(DEPTH);
   localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

   logic [PC_W-1:0] mem_q [DEPTH];
   logic [PW-1:0]   ptr_q;
   logic [PW-1:0]   top_idx;
   logic [PW:0]     cnt_q;
   logic            pop;

   assign top_idx = ptr_q - 1'b1;
   assign top_o   = mem_q[top_idx];
   assign empty_o = (cnt_q == '0);
   assign pop     = pop_i & ~empty_o;

   always_ff @(posedge clk) begin
      if (!rst) begin
         ptr_q <= '0;
         cnt_q <= '0;
      end else if (pop && !push_i) begin
         ptr_q <= top_idx;
         cnt_q <= cnt_q - 1'b1;
      end else if (push_i && !pop) begin
         ptr_q <= ptr_q + 1'b1;
         if (cnt_q != FULL) cnt_q <= cnt_q + 1'b1;
      end
   end

   // Pop-then-push collapses to overwriting the current top in place.
   always_ff @(posedge clk) begin
      if (push_i && pop)  mem_q[top_idx] <= data_i;
      else if (push_i)    mem_q[ptr_q]   <= data_i;
   end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: redirect arbitration, stall-time redirect holding, run/halt control.
// Return-address stack enabled with `define PC_GEN_RAS_EN.
module pc_gen #(
   parameter int unsigned     PC_W      = pc_pkg::PC_W,
   parameter logic [PC_W-1:0] BOOT_ADDR = pc_pkg::BOOT_ADDR,
   parameter int unsigned     RAS_DEPTH = 4
) (
   input logic     clk,
   input logic     rst,
   pc_gen_if.slave fe
);
   import pc_pkg::*;

   fe_state_e       state_q;
   logic [PC_W-1:0] pc_q, pc_d;
   logic            pend_v_q, pend_v_d;
   redir_src_e      pend_src_q, pend_src_d;
   logic [PC_W-1:0] pend_tgt_q, pend_tgt_d;

   redir_src_e      src;
   logic            redir_v;
   logic [PC_W-1:0] tgt;
   logic            run, adv;
   logic            ras_v;
   logic [PC_W-1:0] ras_top;

   assign run = (state_q == RUN);
   assign adv = run & fe.n_stall;

`ifdef PC_GEN_RAS_EN
   logic ras_empty;

   pc_gen_ras #(.PC_W(PC_W), .DEPTH(RAS_DEPTH)) u_ras (
      .clk     (clk),
      .rst     (rst),
      .push_i  (fe.dec_call & adv),
      .pop_i   (fe.dec_ret & adv),
      .data_i  (fe.dec_link),
      .top_o   (ras_top),
      .empty_o (ras_empty)
   );

   assign ras_v = fe.dec_ret & ~ras_empty;
`else
   logic unused_ras;

   assign unused_ras = ^{fe.dec_call, fe.dec_ret, fe.dec_link, RAS_DEPTH[0]};
   assign ras_v      = 1'b0;
   assign ras_top    = '0;
`endif

   always_comb begin
      src     = SRC_PEND;
      redir_v = 1'b1;
      tgt     = '0;
      if (fe.ex_redirect) begin
         src = SRC_EX;
         tgt = fe.ex_target;
      end else if (fe.dec_redirect) begin
         src = SRC_DEC;
         tgt = fe.dec_target;
      end else if (pend_v_q) begin
         src = SRC_PEND;
         tgt = pend_tgt_q;
      end else if (ras_v) begin
         src = SRC_RAS;
         tgt = ras_top;
      end else begin
         redir_v = 1'b0;
      end
   end

   always_comb begin
      pc_d       = pc_q;
      pend_v_d   = pend_v_q;
      pend_src_d = pend_src_q;
      pend_tgt_d = pend_tgt_q;
      if (adv) begin
         pc_d = redir_v ? tgt + 1'b1 : pc_q + 1'b1;
         if (redir_v) pend_v_d = 1'b0;
      end else if (run) begin
         // A held execute target is never displaced by a younger decode jump.
         if (src == SRC_EX || (src == SRC_DEC && !(pend_v_q && pend_src_q == SRC_EX))) begin
            pend_v_d   = 1'b1;
            pend_src_d = src;
            pend_tgt_d = tgt;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= RUN;
         pc_q       <= BOOT_ADDR;
         pend_v_q   <= 1'b0;
         pend_src_q <= SRC_DEC;
         pend_tgt_q <= '0;
      end else begin
         pc_q       <= pc_d;
         pend_v_q   <= pend_v_d;
         pend_src_q <= pend_src_d;
         pend_tgt_q <= pend_tgt_d;
         case (state_q)
            RUN:  if (fe.halt_req && fe.n_stall) state_q <= HALT;
            HALT: if (fe.resume)                 state_q <= RUN;
            default:                             state_q <= RUN;
         endcase
      end
   end

   assign fe.pc          = pc_q;
   assign fe.npc         = tgt;
   assign fe.npc_enn     = run & redir_v;
   assign fe.flush       = run & redir_v;
   assign fe.fetch_valid = run;
   assign fe.halted      = ~run;

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: directed vectors push expectations, a negedge monitor checks.
module tb_pc_gen;

   typedef struct {
      string       nm;
      logic [24:0] pc;
      logic [24:0] npc;
      bit          chk_npc;
      logic        enn;
      logic        fv;
      logic        hl;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_chk = 0;
   int   n_err = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   pc_gen_if #(.PC_W(25)) bus ();

   pc_gen dut (
      .clk (clk),
      .rst (rst),
      .fe  (bus)
   );

   task automatic chk(input string nm, input string fld, input logic [24:0] act, input logic [24:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s.%s: got %h want %h", nm, fld, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         chk(e.nm, "pc", bus.pc, e.pc);
         if (e.chk_npc) chk(e.nm, "npc", bus.npc, e.npc);
         chk(e.nm, "npc_enn", {24'd0, bus.npc_enn}, {24'd0, e.enn});
         chk(e.nm, "flush", {24'd0, bus.flush}, {24'd0, e.enn});
         chk(e.nm, "fetch_valid", {24'd0, bus.fetch_valid}, {24'd0, e.fv});
         chk(e.nm, "halted", {24'd0, bus.halted}, {24'd0, e.hl});
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic step(input string nm, input logic ns, input logic exr, input logic [24:0] ext,
                       input logic decr, input logic [24:0] dect, input logic hr, input logic res,
                       input logic [24:0] epc, input logic [24:0] enpc, input bit cn,
                       input logic een, input logic efv, input logic ehl);
      exp_t e;
      bus.n_stall      = ns;
      bus.ex_redirect  = exr;
      bus.ex_target    = ext;
      bus.dec_redirect = decr;
      bus.dec_target   = dect;
      bus.halt_req     = hr;
      bus.resume       = res;
      e.nm = nm; e.pc = epc; e.npc = enpc; e.chk_npc = cn;
      e.enn = een; e.fv = efv; e.hl = ehl;
      sb.push_back(e);
      tick();
   endtask

   logic [24:0] ret_pc  [5];
   logic [24:0] ret_npc [5];
   logic        ret_enn [5];
   logic [24:0] post_pc;

   initial begin
`ifdef PC_GEN_RAS_EN
      ret_pc  = '{25'd16365, 25'd51, 25'd41, 25'd31, 25'd21};
      ret_npc = '{25'd50, 25'd40, 25'd30, 25'd20, 25'd0};
      ret_enn = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      post_pc = 25'd22;
`else
      ret_pc  = '{25'd16365, 25'd16366, 25'd16367, 25'd16368, 25'd16369};
      ret_npc = '{25'd0, 25'd0, 25'd0, 25'd0, 25'd0};
      ret_enn = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      post_pc = 25'd16370;
`endif
      bus.n_stall = 1'b0; bus.ex_redirect = 1'b0; bus.ex_target = '0;
      bus.dec_redirect = 1'b0; bus.dec_target = '0; bus.halt_req = 1'b0;
      bus.resume = 1'b0; bus.dec_call = 1'b0; bus.dec_ret = 1'b0; bus.dec_link = '0;
      repeat (2) @(posedge clk);
      #1;
      //      name      ns exr ext          decr dect     hr res  pc            npc         cn enn fv hl
      step("reset",    1, 0, 25'd0,       0, 25'd0,   0, 0,  25'd16359,    25'd0,       1, 0, 1, 0);
      rst = 1'b1;
      step("boot0",    1, 0, 25'd0,       0, 25'd0,   0, 0,  25'd16359,    25'd0,       1, 0, 1, 0);
      step("boot1",    1, 0, 25'd0,       0, 25'd0,   0, 0,  25'd16360,    25'd0,       1, 0, 1, 0);
      step("boot2",    1, 0, 25'd0,       0, 25'd0,   0, 0,  25'd16361,    25'd0,       1, 0, 1, 0);
      step("exdec",    1, 1, 25'd100,     1, 25'd200, 0, 0,  25'd16362,    25'd100,     1, 1, 1, 0);
      step("stall1",   0, 0, 25'd0,       1, 25'd50,  0, 0,  25'd101,      25'd50,      1, 1, 1, 0);
      step("stall2",   0, 1, 25'd70,      0, 25'd0,   0, 0,  25'd101,      25'd70,      1, 1, 1, 0);
      step("stall3",   0, 0, 25'd0,       0, 25'd0,   0, 0,  25'd101,      25'd70,      1, 1, 1, 0);
      step("apply",    1, 0, 25'd0,       0, 25'd0,   0, 0,  25'd101,      25'd70,      1, 1, 1, 0);
      step("to39",     1, 1, 25'd39,      0, 25'd0,   0, 0,  25'd71,       25'd39,      1, 1, 1, 0);
      step("halt",     1, 0, 25'd0,       0, 25'd0,   1, 0,  25'd40,       25'd0,       1, 0, 1, 0);
      step("halt_ex",  1, 1, 25'd5,       0, 25'd0,   0, 0,  25'd41,       25'd0,       0, 0, 0, 1);
      step("halt_hd",  1, 0, 25'd0,       0, 25'd0,   0, 0,  25'd41,       25'd0,       1, 0, 0, 1);
      step("resume",   1, 0, 25'd0,       0, 25'd0,   1, 1,  25'd41,       25'd0,       1, 0, 0, 1);
      step("run41",    1, 0, 25'd0,       0, 25'd0,   0, 0,  25'd41,       25'd0,       1, 0, 1, 0);
      step("wrap_tgt", 1, 1, 25'h1FFFFFF, 0, 25'd0,   0, 0,  25'd42,       25'h1FFFFFF, 1, 1, 1, 0);
      step("pc0",      1, 1, 25'h1FFFFFE, 0, 25'd0,   0, 0,  25'd0,        25'h1FFFFFE, 1, 1, 1, 0);
      step("pc_max",   1, 0, 25'd0,       0, 25'd0,   0, 0,  25'h1FFFFFF,  25'd0,       1, 0, 1, 0);
      step("pend",     0, 0, 25'd0,       1, 25'd123, 0, 0,  25'd0,        25'd123,     1, 1, 1, 0);
      rst = 1'b0;
      bus.dec_redirect = 1'b0;
      tick();
      rst = 1'b1;
      step("rst_pend", 0, 0, 25'd0,       0, 25'd0,   0, 0,  25'd16359,    25'd0,       1, 0, 1, 0);
      step("rst_run",  1, 0, 25'd0,       0, 25'd0,   0, 0,  25'd16359,    25'd0,       1, 0, 1, 0);
      for (int unsigned i = 0; i < 5; i++) begin
         bus.dec_call = 1'b1;
         bus.dec_link = 25'(10 * (i + 1));
         step("call", 1, 0, 25'd0, 0, 25'd0, 0, 0, 25'(16360 + i), 25'd0, 1, 0, 1, 0);
      end
      bus.dec_call = 1'b0;
      for (int unsigned i = 0; i < 5; i++) begin
         bus.dec_ret = 1'b1;
         step("ret", 1, 0, 25'd0, 0, 25'd0, 0, 0, ret_pc[i], ret_npc[i], 1, ret_enn[i], 1, 0);
      end
      bus.dec_ret = 1'b0;
      step("post_ret", 1, 0, 25'd0, 0, 25'd0, 0, 0, post_pc, 25'd0, 1, 0, 1, 0);
      for (int unsigned i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
      #1;
      n_chk++;
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL drain: got %0d pending want 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

endmodule
